// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: single-outstanding instruction fetch with prefetch FIFO and redirect flush
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc, req_addr;
  logic [31:0] fifo_inst [DEPTH];
  logic [31:0] fifo_pc [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic pop, push, accept;
  assign pop = stop & (count != '0) & ~redirect;
  assign push = (state == WAIT) & imem_rvalid & ~redirect;
  assign accept = imem_req & imem_ready;
  // state register; reset abandons any outstanding request
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next state: a redirect without a same-cycle response turns the pending word into one to discard
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? WAIT : IDLE;
      WAIT:    state_nx = imem_rvalid ? IDLE : redirect ? DROP : WAIT;
      DROP:    state_nx = imem_rvalid ? IDLE : DROP;
      default: state_nx = IDLE;
    endcase
  end
  // outputs: request only when idle and a FIFO slot is (or is becoming) free; head reads zero when empty
  always_comb begin
    imem_req = (state == IDLE) & ((count < CW'(DEPTH)) | pop) & ~redirect & reset;
    imem_addr = fetch_pc;
    inst_valid = count != '0;
    out_inst = inst_valid ? fifo_inst[rd_ptr] : '0;
    out_pc = inst_valid ? fifo_pc[rd_ptr] : '0;
  end
  // fetch address, captured request address and FIFO bookkeeping; redirect flushes everything
  always_ff @(posedge clk)
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_addr <= fetch_pc;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  // FIFO storage: returned word paired with its PC+4
  always_ff @(posedge clk)
    if (push && reset) begin
      fifo_inst[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr] <= req_addr + 32'd4;
    end
endmodule
